inst_fetch: RTL and testbench



---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_buffer.sv | 60 ++++++
 rtl/inst_fetch.sv | 152 +++++++++++++++
 tb/tb_inst_fetch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: base opcodes, the canonical NOP and the fetch FSM state type.
package riscv_pkg;

    localparam logic [6:0] RTYPE     = 7'b0110011;
    localparam logic [6:0] ITYPEALO  = 7'b0010011;
    localparam logic [6:0] ITYPELOAD = 7'b0000011;
    localparam logic [6:0] STYPE     = 7'b0100011;
    localparam logic [6:0] BTYPE     = 7'b1100011;
    localparam logic [6:0] JTYPE     = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {instruction, pc}; flush beats push, and a pop frees a slot for a same-cycle push.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [31:0]     push_inst,
    input  logic [XLEN-1:0] push_pc,
    input  logic            pop,
    input  logic            flush,
    output logic [1:0]      count,
    output logic [31:0]     head_inst,
    output logic [XLEN-1:0] head_pc
);

    logic [31:0]     inst_r [2];
    logic [XLEN-1:0] pc_r [2];
    logic            rd_ptr_r;
    logic [1:0]      count_r;
    logic            wr_idx_s;
    logic            pop_ok_s;
    logic            push_ok_s;

    // With two slots the write slot is the read slot offset by the occupancy parity.
    assign wr_idx_s  = rd_ptr_r ^ count_r[0];
    assign pop_ok_s  = pop & (count_r != 2'd0) & ~flush;
    assign push_ok_s = push & ~flush & ((count_r != 2'd2) | pop_ok_s);

    // Storage, read pointer and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                inst_r[i] <= NOP_INST;
                pc_r[i]   <= {XLEN{1'b0}};
            end
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                inst_r[wr_idx_s] <= push_inst;
                pc_r[wr_idx_s]   <= push_pc;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
        end
    end

    assign count     = count_r;
    assign head_inst = (count_r != 2'd0) ? inst_r[rd_ptr_r] : NOP_INST;
    assign head_pc   = (count_r != 2'd0) ? pc_r[rd_ptr_r] : {XLEN{1'b0}};

endmodule

// File: rtl/inst_fetch.sv
// RV32I fetch stage: owns the PC, keeps one imem request in flight, buffers two instructions for decode.
// Defining FETCH_PERF_EN adds the perf_fetched / perf_stall counters.
module inst_fetch
    import riscv_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}},
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall
`endif
);

    localparam logic [2:0] DEPTH_C = 3'(BUF_DEPTH);

    fetch_state_t    state_r, state_s;
    logic [XLEN-1:0] pc_r, pc_s;
    logic [XLEN-1:0] fetch_pc_r;
    logic            drop_r, drop_s;
    logic            push_s;
    logic            pop_s;
    logic [1:0]      count_s;
    logic [2:0]      count_after_s;
    logic [31:0]     head_inst_s;
    logic [XLEN-1:0] head_pc_s;

    assign pop_s = inst_valid & inst_ready;

    fetch_buffer #(.XLEN(XLEN)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_inst (imem_rdata[31:0]),
        .push_pc   (fetch_pc_r),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .count     (count_s),
        .head_inst (head_inst_s),
        .head_pc   (head_pc_s)
    );

    // FSM next state; a response already in flight is never cancelled, only marked to be dropped.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        drop_s        = drop_r;
        push_s        = 1'b0;
        count_after_s = {1'b0, count_s} - {2'b00, pop_s};
        case (state_r)
            IDLE: begin
                if (redirect_valid || ({1'b0, count_s} < DEPTH_C)) begin
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (imem_gnt) begin
                    pc_s    = pc_r + XLEN'(32'd4);
                    drop_s  = redirect_valid;
                    state_s = WAIT;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push_s        = ~drop_r & ~redirect_valid;
                    drop_s        = 1'b0;
                    count_after_s = redirect_valid ? 3'd0 : (count_after_s + {2'b00, push_s});
                    state_s       = (count_after_s < DEPTH_C) ? REQ : IDLE;
                end else begin
                    drop_s  = drop_r | redirect_valid;
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        pc_s = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : pc_s;
    end

    // FSM state, PC, drop flag and the address of the request in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            drop_r     <= 1'b0;
            fetch_pc_r <= RESET_PC;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            drop_r  <= drop_s;
            if ((state_r == REQ) && imem_gnt) begin
                fetch_pc_r <= pc_r;
            end
        end
    end

    assign imem_req   = (state_r == REQ);
    assign imem_addr  = pc_r;
    assign inst_valid = (count_s != 2'd0);
    assign inst       = head_inst_s;
    assign inst_pc    = head_pc_s;
    assign opcode     = head_inst_s[6:0];
    assign rd         = head_inst_s[11:7];
    assign funct3     = head_inst_s[14:12];
    assign rs1        = head_inst_s[19:15];
    assign rs2        = head_inst_s[24:20];
    assign funct7     = head_inst_s[31:25];

`ifdef FETCH_PERF_EN
    // Accepted-fetch and decode-starvation counters; cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (push_s) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (inst_ready && !inst_valid) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-based reference of the fetch stream plus directed scenarios.
module tb_inst_fetch;
    import riscv_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_gnt, imem_rvalid, redirect_valid, inst_valid, inst_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall;
    int unsigned perf_f = 0, perf_s = 0;
`endif

    inst_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, passes = 0;
    // reference state
    ent_t        exp_q[$];
    logic [31:0] fetch_pc = 32'h0, out_pc = 32'h0;
    bit          dut_out = 0, dut_drop = 0;
    // memory responder
    bit          mem_pend = 0, gnt_tog = 0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_cnt = 0;
    // knobs and logs
    bit          ready_k = 1, redir_k = 0, redir_on_rv = 0, fired = 0, post_redir_chk = 0;
    int          rv_delay = 1, gnt_mode = 0, idle_run = 0, fire_gl = 0, cyc = 0;
    logic [31:0] redir_t = 32'h0;
    logic [31:0] gnt_log[$], pop_log[$];
    int          first_valid_cyc = -1;
    logic [31:0] first_inst, first_pc;
    logic [6:0]  first_op;
    logic [4:0]  first_rd;
    logic [2:0]  first_f3;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 ^ {a[11:0], 20'h0_0000};
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        else passes++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Drive memory/decode inputs, check outputs against the reference, then advance it.
    initial begin : drive_check
        bit          rv, g, rdv, rdy, ex_v, pushed;
        logic [31:0] rv_data, ex_w, ex_pc;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 32'h0;
        redirect_valid = 0; redirect_pc = 32'h0; inst_ready = 0;
        forever begin
            @(negedge clk);
            rv      = mem_pend && (mem_cnt == 1);
            rv_data = mem_word(mem_addr);
            if (mem_pend) begin
                if (mem_cnt == 1) mem_pend = 0;
                else              mem_cnt--;
            end
            if (!rst_n) begin
                exp_q.delete(); fetch_pc = 32'h0; dut_out = 0; dut_drop = 0;
                idle_run = 0; post_redir_chk = 0;
`ifdef FETCH_PERF_EN
                perf_f = 0; perf_s = 0;
`endif
                imem_gnt = 0; imem_rvalid = rv; imem_rdata = rv ? rv_data : 32'h0;
                redirect_valid = 0; inst_ready = ready_k;
            end else begin
                ex_v  = exp_q.size() > 0;
                ex_w  = ex_v ? exp_q[0].word : NOP_INST;
                ex_pc = ex_v ? exp_q[0].pc : 32'h0;
                chk("inst_valid", 32'(inst_valid), 32'(ex_v));
                chk("inst", inst, ex_w);
                chk("inst_pc", inst_pc, ex_pc);
                chk("fields", {opcode, funct3, funct7, rd, rs1, rs2},
                    {ex_w[6:0], ex_w[14:12], ex_w[31:25], ex_w[11:7], ex_w[19:15], ex_w[24:20]});
                if (post_redir_chk) chk("flush_next", 32'(inst_valid), 32'd0);
                post_redir_chk = 0;
                if (imem_req) chk("req_addr", imem_addr, fetch_pc);
                chk("req_when_full", 32'(imem_req && (exp_q.size() >= 2)), 32'd0);
                chk("req_outstanding", 32'(imem_req && dut_out), 32'd0);
                idle_run = (!imem_req && !dut_out && exp_q.size() < 2) ? idle_run + 1 : 0;
                chk("liveness", 32'(idle_run > 4), 32'd0);
`ifdef FETCH_PERF_EN
                chk("perf_fetched", perf_fetched, perf_f);
                chk("perf_stall", perf_stall, perf_s);
`endif
                if (inst_valid && first_valid_cyc < 0) begin
                    first_valid_cyc = cyc; first_inst = inst; first_pc = inst_pc;
                    first_op = opcode; first_rd = rd; first_f3 = funct3;
                end
                // inputs for the coming edge
                gnt_tog = ~gnt_tog;
                g = imem_req && !mem_pend && (gnt_mode == 0 || gnt_tog);
                if (g) begin
                    mem_pend = 1; mem_addr = imem_addr; mem_cnt = rv_delay;
                    gnt_log.push_back(imem_addr);
                end
                rdy = ready_k; rdv = 0;
                if (redir_k) begin
                    rdv = 1; redir_k = 0;
                end else if (redir_on_rv && rv && ex_v) begin
                    rdv = 1; rdy = 1; redir_on_rv = 0;
                end
                if (rdv) begin post_redir_chk = 1; fired = 1; fire_gl = gnt_log.size(); end
                imem_gnt = g; imem_rvalid = rv; imem_rdata = rv ? rv_data : 32'h0;
                inst_ready = rdy; redirect_valid = rdv; redirect_pc = redir_t;
                // reference update for the coming edge
                pushed = 0;
`ifdef FETCH_PERF_EN
                if (rdy && !ex_v) perf_s++;
`endif
                if (rdv) exp_q.delete();
                else if (ex_v && rdy) begin
                    pop_log.push_back(exp_q[0].pc);
                    void'(exp_q.pop_front());
                end
                if (rv && dut_out) begin
                    if (!dut_drop && !rdv) begin
                        exp_q.push_back(ent_t'{pc: out_pc, word: mem_word(out_pc)});
                        pushed = 1;
                    end
                    dut_out = 0; dut_drop = 0;
                end else if (rdv && dut_out) begin
                    dut_drop = 1;
                end
                if (g) begin
                    dut_out = 1; dut_drop = rdv; out_pc = imem_addr;
                    if (!rdv) fetch_pc = fetch_pc + 32'd4;
                end
                if (rdv) fetch_pc = {redir_t[31:2], 2'b00};
`ifdef FETCH_PERF_EN
                if (pushed) perf_f++;
`endif
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_pc", inst_pc, 32'h0);
`ifdef FETCH_PERF_EN
        chk("rst_perf", perf_fetched | perf_stall, 32'h0);
`endif
        gnt_log.delete(); pop_log.delete(); first_valid_cyc = -1;
        @(negedge clk);
        #1 rst_n = 1;
    endtask

    task automatic wait_outstanding();
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (dut_out && !dut_drop) begin ok = 1; break; end
        end
        chk("wait_outstanding", 32'(ok), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gl, pl;
        // streaming fetch after reset
        ready_k = 1; gnt_mode = 0; rv_delay = 1;
        do_reset();
        step(12);
        chk("first_addr0", qat(gnt_log, 0), 32'h0);
        chk("first_addr1", qat(gnt_log, 1), 32'h4);
        chk("first_addr2", qat(gnt_log, 2), 32'h8);
        chk("first_valid_cycle", 32'(first_valid_cyc), 32'd3);
        chk("first_inst", first_inst, 32'h0050_0093);
        chk("first_decode", {25'h0, first_op, first_rd, first_f3} >> 0, {25'h0, 7'h13, 5'd1, 3'd0});
        chk("first_pc", first_pc, 32'h0);
        // back-pressure fills the buffer, then drains in order
        ready_k = 0;
        do_reset();
        step(10);
        chk("full_grants", 32'(gnt_log.size()), 32'd2);
        chk("full_req", 32'(imem_req), 32'd0);
        chk("full_head_pc", inst_pc, 32'h0);
        ready_k = 1;
        step(8);
        chk("drain0", qat(pop_log, 0), 32'h0);
        chk("drain1", qat(pop_log, 1), 32'h4);
        chk("drain2", qat(pop_log, 2), 32'h8);
        // redirect while waiting on memory
        rv_delay = 3;
        wait_outstanding();
        pl = pop_log.size();
        redir_t = 32'h0000_0103; redir_k = 1;
        step(12);
        chk("redir_wait_addr", qat(gnt_log, fire_gl), 32'h100);
        chk("redir_wait_pc", qat(pop_log, pl), 32'h100);
        // redirect coinciding with rvalid and a pop
        rv_delay = 1; ready_k = 0; redir_t = 32'h0000_0200; fired = 0; redir_on_rv = 1;
        for (int i = 0; i < 30 && !fired; i++) step(1);
        chk("redir_rv_fired", 32'(fired), 32'd1);
        ready_k = 1;
        step(8);
        chk("redir_rv_addr", qat(gnt_log, fire_gl), 32'h200);
        // PC wrap, with grants held off on alternate cycles
        gnt_mode = 1; redir_t = 32'hFFFF_FFFC; redir_k = 1;
        step(16);
        chk("wrap_addr0", qat(gnt_log, fire_gl), 32'hFFFF_FFFC);
        chk("wrap_addr1", qat(gnt_log, fire_gl + 1), 32'h0);
        // reset with a response still in flight; the late rvalid must be ignored
        gnt_mode = 0; rv_delay = 3;
        wait_outstanding();
        rst_n = 0;
        #1;
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_valid", 32'(inst_valid), 32'd0);
        chk("midrst_addr", imem_addr, 32'h0);
        gnt_log.delete(); pop_log.delete();
        @(negedge clk);
        #1 rst_n = 1;
        step(16);
        chk("midrst_grant0", qat(gnt_log, 0), 32'h0);
        chk("midrst_pop0", qat(pop_log, 0), 32'h0);
        chk("midrst_pop1", qat(pop_log, 1), 32'h4);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
